// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// counter width default, stage-control bundle and the branch-resolution helper.
package pipe_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_SQUASH   = 2'd2;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic redirect;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN      = 8'b1111_0000;
    localparam ctrl_t CTRL_TAKEN    = 8'b1111_1111;
    localparam ctrl_t CTRL_HOLD     = 8'b0000_0000;
    localparam ctrl_t CTRL_LOAD_USE = 8'b0011_0100;
    localparam ctrl_t CTRL_RESET    = 8'b0000_1110;

    function automatic logic branch_taken(
        input logic jump,
        input logic jalr,
        input logic blt,
        input logic bge,
        input logic lt
    );
        return jump | jalr | (blt & lt) | (bge & ~lt);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_lw;
    logic             mem_jump;
    logic             mem_jalr;
    logic             mem_blt;
    logic             mem_bge;
    logic             mem_lt;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             redirect;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_lw,
               mem_jump, mem_jalr, mem_blt, mem_bge, mem_lt, dmem_req, dmem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
               exmem_flush, redirect, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_lw,
               mem_jump, mem_jalr, mem_blt, mem_bge, mem_lt, dmem_req, dmem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
               exmem_flush, redirect, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_cmp.sv
// Load-use detector: the ID/EX load writes a register the IF/ID instruction
// reads. x0 never creates a hazard.
module hazard_cmp (
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_lw,
    output logic       o_load_use
);
    logic w_rd_nonzero;
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_rd_nonzero = (i_ex_rd != 5'd0);
    assign w_hit_rs1    = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
    assign w_hit_rs2    = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_load_use   = i_ex_lw & w_rd_nonzero & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls for load-use and data-memory waits,
// squashes three stages on a taken control transfer, counts stall/flush cycles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
)(
    input  logic             clk,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [1:0]       w_next_state;
    logic             w_taken;
    logic             w_load_use;
    logic             w_mem_stall;
    logic             w_stall_inc;
    logic             w_flush_inc;
    ctrl_t            w_ctrl;
    ctrl_t            w_out;

    assign w_taken     = branch_taken(bus.mem_jump, bus.mem_jalr, bus.mem_blt,
                                      bus.mem_bge, bus.mem_lt);
    assign w_mem_stall = bus.dmem_req & ~bus.dmem_ready;

    hazard_cmp u_cmp (
        .i_id_rs1     (bus.id_rs1),
        .i_id_rs2     (bus.id_rs2),
        .i_id_use_rs1 (bus.id_use_rs1),
        .i_id_use_rs2 (bus.id_use_rs2),
        .i_ex_rd      (bus.ex_rd),
        .i_ex_lw      (bus.ex_lw),
        .o_load_use   (w_load_use)
    );

    // Next state and stage controls; a taken transfer outranks memory and load-use stalls
    always_comb begin
        w_next_state = ST_RUN;
        w_ctrl       = CTRL_RESET;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_taken) begin
                    w_ctrl       = CTRL_TAKEN;
                    w_next_state = ST_SQUASH;
                    w_flush_inc  = 1'b1;
                end else if (w_mem_stall) begin
                    w_ctrl       = CTRL_HOLD;
                    w_next_state = ST_MEM_WAIT;
                    w_stall_inc  = 1'b1;
                end else if (w_load_use) begin
                    w_ctrl       = CTRL_LOAD_USE;
                    w_next_state = ST_RUN;
                    w_stall_inc  = 1'b1;
                end else begin
                    w_ctrl       = CTRL_RUN;
                    w_next_state = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.dmem_ready) begin
                    w_ctrl       = CTRL_HOLD;
                    w_next_state = ST_MEM_WAIT;
                    w_stall_inc  = 1'b1;
                end else begin
                    w_ctrl       = CTRL_RUN;
                    w_next_state = ST_RUN;
                end
            end
            ST_SQUASH: begin
                w_ctrl       = CTRL_RUN;
                w_next_state = ST_RUN;
            end
            default: begin
                w_ctrl       = CTRL_RESET;
                w_next_state = ST_RUN;
            end
        endcase
    end

    // Reset forces the safe pattern on the outputs without waiting for a clock
    always_comb begin
        w_out = CTRL_RESET;
        if (reset) begin
            w_out = CTRL_RESET;
        end else begin
            w_out = w_ctrl;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_inc && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign bus.pc_we       = w_out.pc_we;
    assign bus.ifid_we     = w_out.ifid_we;
    assign bus.idex_we     = w_out.idex_we;
    assign bus.exmem_we    = w_out.exmem_we;
    assign bus.ifid_flush  = w_out.ifid_flush;
    assign bus.idex_flush  = w_out.idex_flush;
    assign bus.exmem_flush = w_out.exmem_flush;
    assign bus.redirect    = w_out.redirect;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: cycle-by-cycle vector table plus
// hand sequences for reset-in-wait and counter saturation.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pipe_hazard_ctrl_if #(.CNT_W(16)) b16 ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  b4 ();

    pipe_hazard_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));
    pipe_hazard_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(b4.slave));

    assign b4.id_rs1     = b16.id_rs1;
    assign b4.id_rs2     = b16.id_rs2;
    assign b4.id_use_rs1 = b16.id_use_rs1;
    assign b4.id_use_rs2 = b16.id_use_rs2;
    assign b4.ex_rd      = b16.ex_rd;
    assign b4.ex_lw      = b16.ex_lw;
    assign b4.mem_jump   = b16.mem_jump;
    assign b4.mem_jalr   = b16.mem_jalr;
    assign b4.mem_blt    = b16.mem_blt;
    assign b4.mem_bge    = b16.mem_bge;
    assign b4.mem_lt     = b16.mem_lt;
    assign b4.dmem_req   = b16.dmem_req;
    assign b4.dmem_ready = b16.dmem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs: rs1, rs2, use1, use2, rd, lw, jump, jalr, blt, bge, lt, req, ready
    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [4:0]  rd;
        logic        lw;
        logic [4:0]  br;      // {jump, jalr, blt, bge, lt}
        logic        req;
        logic        rdy;
        logic [7:0]  exp_ctrl; // {pc,ifid,idex,exmem,f_ifid,f_idex,f_exmem,redirect}
        logic [15:0] exp_stall;
        logic [15:0] exp_flush;
    } vec_t;

    localparam logic [7:0] NRM = 8'b1111_0000;
    localparam logic [7:0] TKN = 8'b1111_1111;
    localparam logic [7:0] WT  = 8'b0000_0000;
    localparam logic [7:0] LU  = 8'b0011_0100;
    localparam logic [7:0] RST = 8'b0000_1110;

    vec_t vecs [22];

    function automatic logic [7:0] ctrl16();
        return {b16.pc_we, b16.ifid_we, b16.idex_we, b16.exmem_we,
                b16.ifid_flush, b16.idex_flush, b16.exmem_flush, b16.redirect};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                         input logic use2, input logic [4:0] rd, input logic lw,
                         input logic [4:0] br, input logic req, input logic rdy);
        b16.id_rs1     = rs1;
        b16.id_rs2     = rs2;
        b16.id_use_rs1 = use1;
        b16.id_use_rs2 = use2;
        b16.ex_rd      = rd;
        b16.ex_lw      = lw;
        {b16.mem_jump, b16.mem_jalr, b16.mem_blt, b16.mem_bge, b16.mem_lt} = br;
        b16.dmem_req   = req;
        b16.dmem_ready = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00000, 1'b0, 1'b0);
    endtask

    task automatic load_use_in();
        drive(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 5'b00000, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic use1, input logic use2, input logic [4:0] rd,
                                input logic lw, input logic [4:0] br, input logic req,
                                input logic rdy, input logic [7:0] ec,
                                input logic [15:0] es, input logic [15:0] ef);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2; v.rd = rd; v.lw = lw;
        v.br = br; v.req = req; v.rdy = rdy;
        v.exp_ctrl = ec; v.exp_stall = es; v.exp_flush = ef;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        //            rs1    rs2    u1    u2    rd     lw    {j,jr,blt,bge,lt} req rdy  ctrl stall flush
        vecs[0]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00000, 1'b0, 1'b0, NRM, 16'd0, 16'd0);
        vecs[1]  = mk(5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 5'b00000, 1'b0, 1'b0, LU,  16'd0, 16'd0);
        vecs[2]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00000, 1'b0, 1'b0, NRM, 16'd1, 16'd0);
        vecs[3]  = mk(5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 5'b00000, 1'b0, 1'b0, NRM, 16'd1, 16'd0);
        vecs[4]  = mk(5'd7,  5'd0,  1'b0, 1'b0, 5'd7,  1'b1, 5'b00000, 1'b0, 1'b0, NRM, 16'd1, 16'd0);
        vecs[5]  = mk(5'd7,  5'd0,  1'b1, 1'b0, 5'd7,  1'b0, 5'b00000, 1'b0, 1'b0, NRM, 16'd1, 16'd0);
        vecs[6]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00101, 1'b0, 1'b0, TKN, 16'd1, 16'd0);
        vecs[7]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b10000, 1'b0, 1'b0, NRM, 16'd1, 16'd1);
        vecs[8]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00010, 1'b0, 1'b0, TKN, 16'd1, 16'd1);
        vecs[9]  = mk(5'd3,  5'd0,  1'b1, 1'b0, 5'd3,  1'b1, 5'b00000, 1'b1, 1'b0, NRM, 16'd1, 16'd2);
        vecs[10] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00100, 1'b0, 1'b0, NRM, 16'd1, 16'd2);
        vecs[11] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b01000, 1'b0, 1'b0, TKN, 16'd1, 16'd2);
        vecs[12] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00011, 1'b0, 1'b0, NRM, 16'd1, 16'd3);
        vecs[13] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00011, 1'b1, 1'b1, NRM, 16'd1, 16'd3);
        vecs[14] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00000, 1'b1, 1'b0, WT,  16'd1, 16'd3);
        vecs[15] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00000, 1'b1, 1'b0, WT,  16'd2, 16'd3);
        vecs[16] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00000, 1'b1, 1'b0, WT,  16'd3, 16'd3);
        vecs[17] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00000, 1'b1, 1'b1, NRM, 16'd4, 16'd3);
        vecs[18] = mk(5'd9,  5'd0,  1'b1, 1'b0, 5'd9,  1'b1, 5'b00000, 1'b0, 1'b0, LU,  16'd4, 16'd3);
        vecs[19] = mk(5'd9,  5'd0,  1'b1, 1'b0, 5'd9,  1'b1, 5'b10000, 1'b1, 1'b0, TKN, 16'd5, 16'd3);
        vecs[20] = mk(5'd9,  5'd0,  1'b1, 1'b0, 5'd9,  1'b1, 5'b10000, 1'b1, 1'b0, NRM, 16'd5, 16'd4);
        vecs[21] = mk(5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'b00000, 1'b0, 1'b0, NRM, 16'd5, 16'd4);

        // Reset state
        reset = 1'b1;
        idle();
        @(negedge clk);
        #2;
        check("reset_ctrl", 0, {24'd0, ctrl16()}, {24'd0, RST});
        check("reset_stall", 0, {16'd0, b16.stall_cnt}, 32'd0);
        check("reset_flush", 0, {16'd0, b16.flush_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Cycle-by-cycle vector table
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2, vecs[i].rd,
                  vecs[i].lw, vecs[i].br, vecs[i].req, vecs[i].rdy);
            #2;
            check("vec_ctrl", i, {24'd0, ctrl16()}, {24'd0, vecs[i].exp_ctrl});
            check("vec_stall", i, {16'd0, b16.stall_cnt}, {16'd0, vecs[i].exp_stall});
            check("vec_flush", i, {16'd0, b16.flush_cnt}, {16'd0, vecs[i].exp_flush});
            @(negedge clk);
        end

        // Reset asserted in the middle of a memory wait
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00000, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        check("wait_before_reset", 0, {24'd0, ctrl16()}, {24'd0, WT});
        reset = 1'b1;
        #1;
        check("mid_wait_reset_ctrl", 0, {24'd0, ctrl16()}, {24'd0, RST});
        check("mid_wait_reset_stall", 0, {16'd0, b16.stall_cnt}, 32'd0);
        check("mid_wait_reset_flush", 0, {16'd0, b16.flush_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        #2;
        check("post_reset_run", 0, {24'd0, ctrl16()}, {24'd0, NRM});
        check("post_reset_stall", 0, {16'd0, b16.stall_cnt}, 32'd0);
        @(negedge clk);
        #2;
        check("post_reset_run", 1, {24'd0, ctrl16()}, {24'd0, NRM});
        check("post_reset_stall", 1, {16'd0, b16.stall_cnt}, 32'd0);
        check("post_reset_flush", 1, {16'd0, b16.flush_cnt}, 32'd0);
        @(negedge clk);

        // Twenty load-use stall cycles: 16-bit counter reaches 20, 4-bit saturates at 15
        load_use_in();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
        end
        idle();
        #2;
        check("sat_stall16", 0, {16'd0, b16.stall_cnt}, 32'd20);
        check("sat_stall4", 0, {28'd0, b4.stall_cnt}, 32'd15);
        @(negedge clk);
        #2;
        check("sat_stall4_hold", 1, {28'd0, b4.stall_cnt}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in IF/ID.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  input  1 each  the IF/ID instruction reads rs1/rs2.
REQ-006 SHALL have ports ex_rd  input  5  and ex_lw  input  1  destination register and load flag of the ID/EX instruction.
REQ-007 SHALL have ports mem_jump, mem_jalr, mem_blt, mem_bge, mem_lt  input  1 each  EX/MEM control-flow flags; mem_lt is the signed rs1<rs2 result.
REQ-008 SHALL have ports dmem_req  input  1  (MEM-stage load or store active) and dmem_ready  input  1  (data memory completes this cycle).
REQ-009 SHALL have ports pc_we, ifid_we, idex_we, exmem_we  output  1 each  stage write enables.
REQ-010 SHALL have ports ifid_flush, idex_flush, exmem_flush  output  1 each  synchronous bubble insertion.
REQ-011 SHALL have port redirect  output  1  PC mux selects the MEM-stage target.
REQ-012 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-013 SHALL compute taken = mem_jump | mem_jalr | (mem_blt & mem_lt) | (mem_bge & ~mem_lt).
REQ-014 SHALL compute load_use = ex_lw & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
REQ-015 SHALL implement FSM states RUN, MEM_WAIT, SQUASH; RUN is the reset state.
REQ-016 RUN, taken=1 (highest priority): redirect=1, pc_we=1, all three flushes=1, all other enables=1; next state SQUASH; flush_cnt increments.
REQ-017 RUN, taken=0, dmem_req=1, dmem_ready=0: all enables=0, flushes=0; next state MEM_WAIT; stall_cnt increments.
REQ-018 RUN, no taken, no memory wait, load_use=1: pc_we=0, ifid_we=0, idex_flush=1, idex_we=1, exmem_we=1; stays RUN; stall_cnt increments.
REQ-019 RUN, none of the above: all enables=1, flushes=0, redirect=0.
REQ-020 MEM_WAIT, dmem_ready=0: all enables=0; stall_cnt increments every cycle.
REQ-021 MEM_WAIT, dmem_ready=1: all enables=1, no stall_cnt increment; next state RUN; load_use is re-evaluated in RUN on the next cycle.
REQ-022 SQUASH lasts exactly one cycle: taken, load_use and dmem_req are ignored; all enables=1, flushes=0, redirect=0; next state RUN.
REQ-023 A taken branch coinciding with dmem_req SHALL take the redirect path; the memory request is dropped.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 Control-hazard penalty SHALL be 3 cycles (IF/ID, ID/EX, EX/MEM flushed); load-use penalty SHALL be 1 cycle.

Reset
REQ-026 While reset=1: state=RUN, stall_cnt=flush_cnt=0, all enables=0, all flushes=1, redirect=0.
REQ-027 Reset asserted in MEM_WAIT or SQUASH SHALL abort immediately to RUN; the first cycle after deassertion SHALL behave as RUN.

Structure
REQ-028 State encoding and the default CNT_W SHALL live in shared package pipe_ctrl_pkg.
REQ-029 The load_use comparator SHALL be a sub-module hazard_cmp (pure combinational); FSM and counters stay in pipe_hazard_ctrl.

Verification
REQ-030 Load-use: ex_lw=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle pc_we=0, ifid_we=0, idex_flush=1; stall_cnt=1.
REQ-031 Taken blt: mem_blt=1, mem_lt=1 -> redirect=1, three flushes=1, next cycle SQUASH with mem_jump=1 ignored; flush_cnt=1.
REQ-032 Memory wait: dmem_req=1, dmem_ready low for 3 cycles then high -> enables 0 for 3 cycles, 1 on the ready cycle; stall_cnt=3.
REQ-033 Priority: taken=1 with dmem_req=1, dmem_ready=0 and load_use=1 -> redirect path only, state SQUASH, stall_cnt unchanged.
REQ-034 x0 and saturation: ex_rd=0 with matching rs1 -> no stall; CNT_W=4 with 20 stall cycles -> stall_cnt=15.
REQ-035 Reset in MEM_WAIT: assert reset mid-wait -> outputs at REQ-026 values at once; after release state RUN, counters 0.
